// File: rtl/cus19_crypto_engine.sv
// rtl/cus19_crypto_engine.sv - block cipher engine: fetches words, runs rotate/xor rounds, writes results back
module cus19_crypto_engine #(
  parameter int DATA_W      = 19,
  parameter int ADDR_W      = 8,
  parameter int BLOCK_WORDS = 4,
  parameter int ROUNDS      = 4,
  parameter int ROT         = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_in,
  input  logic              mode_enc_dec_in,
  input  logic [DATA_W-1:0] key_in,
  input  logic [ADDR_W-1:0] src_addr_in,
  input  logic [ADDR_W-1:0] dst_addr_in,
  output logic              mem_rd_en_out,
  output logic              mem_wr_en_out,
  output logic [ADDR_W-1:0] mem_addr_out,
  output logic [DATA_W-1:0] mem_wdata_out,
  input  logic [DATA_W-1:0] mem_rdata_in,
  output logic              busy_out,
  output logic              done_out
);

  localparam int IW = (BLOCK_WORDS > 1) ? $clog2(BLOCK_WORDS) : 1;
  localparam int RW = (ROUNDS > 1) ? $clog2(ROUNDS) : 1;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_REQ  = 3'd1,
    RD_WAIT = 3'd2,
    ROUND   = 3'd3,
    WR      = 3'd4,
    DONE    = 3'd5
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [IW-1:0]     idx;
  logic [RW-1:0]     r;
  logic [DATA_W-1:0] x;
  logic [DATA_W-1:0] key_q;
  logic              mode_q;
  logic [ADDR_W-1:0] src_q;
  logic [ADDR_W-1:0] dst_q;

  logic              last_word;
  logic              last_round;
  int                enc_i;
  int                dec_i;
  logic [DATA_W-1:0] x_enc;
  logic [DATA_W-1:0] x_dec;
  logic [DATA_W-1:0] x_round;

  // Rotation by any amount; a zero amount leaves the value unchanged.
  function automatic logic [DATA_W-1:0] rotl(input logic [DATA_W-1:0] v, input int n);
    int s;
    s = n % DATA_W;
    return (v << s) | (v >> (DATA_W - s));
  endfunction

  function automatic logic [DATA_W-1:0] rotr(input logic [DATA_W-1:0] v, input int n);
    return rotl(v, DATA_W - (n % DATA_W));
  endfunction

  assign last_word  = (idx == IW'(BLOCK_WORDS - 1));
  assign last_round = (r == RW'(ROUNDS - 1));

  // Decrypt walks the round keys backwards and undoes each step in reverse order.
  always_comb begin
    enc_i   = int'(r);
    dec_i   = ROUNDS - 1 - int'(r);
    x_enc   = rotl(x ^ rotl(key_q, enc_i), ROT);
    x_dec   = rotr(x, ROT) ^ rotl(key_q, dec_i);
    x_round = mode_q ? x_enc : x_dec;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start_in) state_nxt = RD_REQ;
      RD_REQ:  state_nxt = RD_WAIT;
      RD_WAIT: state_nxt = ROUND;
      ROUND:   if (last_round) state_nxt = WR;
      WR:      state_nxt = last_word ? DONE : RD_REQ;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      idx    <= '0;
      r      <= '0;
      x      <= '0;
      key_q  <= '0;
      mode_q <= 1'b0;
      src_q  <= '0;
      dst_q  <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (start_in) begin
            mode_q <= mode_enc_dec_in;
            key_q  <= key_in;
            src_q  <= src_addr_in;
            dst_q  <= dst_addr_in;
            idx    <= '0;
          end
        end
        RD_WAIT: begin
          x <= mem_rdata_in;
          r <= '0;
        end
        ROUND: begin
          x <= x_round;
          r <= r + RW'(1);
        end
        WR: begin
          if (!last_word) idx <= idx + IW'(1);
        end
        default: ;
      endcase
    end
  end

  // Outputs decode registered state only; address wraps naturally at ADDR_W bits.
  always_comb begin
    mem_rd_en_out = (state == RD_REQ);
    mem_wr_en_out = (state == WR);
    busy_out      = (state != IDLE);
    done_out      = (state == DONE);
    mem_addr_out  = '0;
    mem_wdata_out = '0;
    if (state == RD_REQ) begin
      mem_addr_out = src_q + ADDR_W'(idx);
    end else if (state == WR) begin
      mem_addr_out  = dst_q + ADDR_W'(idx);
      mem_wdata_out = x;
    end
  end

endmodule

// File: tb/tb_cus19_crypto_engine.sv
// tb/tb_cus19_crypto_engine.sv - directed self-checking bench for cus19_crypto_engine
module tb_cus19_crypto_engine;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_in;
  logic        mode_enc_dec_in;
  logic [18:0] key_in;
  logic [7:0]  src_addr_in;
  logic [7:0]  dst_addr_in;
  logic        mem_rd_en_out;
  logic        mem_wr_en_out;
  logic [7:0]  mem_addr_out;
  logic [18:0] mem_wdata_out;
  logic [18:0] mem_rdata_in;
  logic        busy_out;
  logic        done_out;

  cus19_crypto_engine dut (
    .clk             (clk),
    .rst             (rst),
    .start_in        (start_in),
    .mode_enc_dec_in (mode_enc_dec_in),
    .key_in          (key_in),
    .src_addr_in     (src_addr_in),
    .dst_addr_in     (dst_addr_in),
    .mem_rd_en_out   (mem_rd_en_out),
    .mem_wr_en_out   (mem_wr_en_out),
    .mem_addr_out    (mem_addr_out),
    .mem_wdata_out   (mem_wdata_out),
    .mem_rdata_in    (mem_rdata_in),
    .busy_out        (busy_out),
    .done_out        (done_out)
  );

  always #5 clk = ~clk;

  // Data memory model with a one-cycle read latency and a bench-side preload port.
  logic [18:0] mem [256];
  logic        poke_en;
  logic [7:0]  poke_addr;
  logic [18:0] poke_data;

  always @(posedge clk) begin
    if (poke_en) mem[poke_addr] <= poke_data;
    else if (mem_wr_en_out) mem[mem_addr_out] <= mem_wdata_out;
    mem_rdata_in <= mem_rd_en_out ? mem[mem_addr_out] : 19'h0;
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  int          done_cyc, done_cnt, wr_n, rd_n, busy_first, busy_last, busy_cnt, both_cnt;
  int          wr_cyc [8];
  int          rd_cyc [8];
  logic [7:0]  wr_a [8];
  logic [7:0]  rd_a [8];
  logic [18:0] rnd [4];
  logic [18:0] rkey;
  int          wr_after_rst;

  task automatic poke(input logic [7:0] a, input logic [18:0] d);
    @(negedge clk);
    poke_en = 1'b1; poke_addr = a; poke_data = d;
    @(negedge clk);
    poke_en = 1'b0;
  endtask

  task automatic check_idle_outputs(input string tag);
    check_eq({tag, "_busy"},  busy_out,      0);
    check_eq({tag, "_done"},  done_out,      0);
    check_eq({tag, "_rd"},    mem_rd_en_out, 0);
    check_eq({tag, "_wr"},    mem_wr_en_out, 0);
    check_eq({tag, "_addr"},  mem_addr_out,  0);
    check_eq({tag, "_wdata"}, mem_wdata_out, 0);
  endtask

  // Start is seen at the edge closing cycle 0; cycle c is sampled at the following negedges.
  task automatic run_op(input logic m, input logic [18:0] k, input logic [7:0] s,
                        input logic [7:0] d, input bit hold);
    @(negedge clk);
    start_in = 1'b1; mode_enc_dec_in = m; key_in = k; src_addr_in = s; dst_addr_in = d;
    done_cyc = -1; done_cnt = 0; wr_n = 0; rd_n = 0;
    busy_first = -1; busy_last = -1; busy_cnt = 0; both_cnt = 0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (mem_rd_en_out) begin
        if (rd_n < 8) begin rd_cyc[rd_n] = c; rd_a[rd_n] = mem_addr_out; end
        rd_n++;
      end
      if (mem_wr_en_out) begin
        if (wr_n < 8) begin wr_cyc[wr_n] = c; wr_a[wr_n] = mem_addr_out; end
        wr_n++;
      end
      if (mem_rd_en_out && mem_wr_en_out) both_cnt++;
      if (done_out) begin done_cnt++; done_cyc = c; end
      if (busy_out) begin
        busy_cnt++;
        if (busy_first < 0) busy_first = c;
        busy_last = c;
      end
      if (c == 1) begin
        key_in = ~k; src_addr_in = 8'hAA; dst_addr_in = 8'hBB; mode_enc_dec_in = ~m;
      end
      if (!hold || (done_cyc >= 0 && c > done_cyc)) start_in = 1'b0;
    end
    start_in = 1'b0;
  endtask

  initial begin
    rst = 1'b1; start_in = 1'b0; mode_enc_dec_in = 1'b0; key_in = '0;
    src_addr_in = '0; dst_addr_in = '0; poke_en = 1'b0; poke_addr = '0; poke_data = '0;
    repeat (3) @(negedge clk);
    check_idle_outputs("reset");
    rst = 1'b0;

    // Key 0 encrypt: pure 12-bit rotation per word.
    poke(8'h10, 19'h00001); poke(8'h11, 19'h00002); poke(8'h12, 19'h40000); poke(8'h13, 19'h00000);
    run_op(1'b1, 19'h0, 8'h10, 8'h20, 1'b0);
    check_eq("k0_w0", mem[8'h20], 19'h01000);
    check_eq("k0_w1", mem[8'h21], 19'h02000);
    check_eq("k0_w2", mem[8'h22], 19'h00800);
    check_eq("k0_w3", mem[8'h23], 19'h00000);
    check_eq("k0_done_cyc", done_cyc, 29);
    check_eq("k0_done_cnt", done_cnt, 1);
    check_eq("k0_wr_cyc0", wr_cyc[0], 7);
    check_eq("k0_wr_cyc1", wr_cyc[1], 14);
    check_eq("k0_wr_cyc2", wr_cyc[2], 21);
    check_eq("k0_wr_cyc3", wr_cyc[3], 28);
    check_eq("k0_busy_first", busy_first, 1);
    check_eq("k0_busy_last", busy_last, 29);
    check_eq("k0_busy_cnt", busy_cnt, 29);
    check_eq("k0_strobe_excl", both_cnt, 0);
    check_eq("k0_rd_a0", rd_a[0], 8'h10);

    // All-ones key: round keys are constant and cancel in pairs.
    poke(8'h30, 19'h00001); poke(8'h31, 19'h00000); poke(8'h32, 19'h00001); poke(8'h33, 19'h00000);
    run_op(1'b1, 19'h7FFFF, 8'h30, 8'h38, 1'b0);
    check_eq("kf_enc_w0", mem[8'h38], 19'h01000);
    check_eq("kf_enc_w1", mem[8'h39], 19'h00000);
    run_op(1'b0, 19'h7FFFF, 8'h38, 8'h3C, 1'b0);
    check_eq("kf_dec_w0", mem[8'h3C], 19'h00001);
    check_eq("kf_dec_w1", mem[8'h3D], 19'h00000);

    // Random round trip, separate buffers and then in place.
    rkey = 19'($urandom());
    for (int i = 0; i < 4; i++) rnd[i] = 19'($urandom());
    for (int i = 0; i < 4; i++) poke(8'h50 + 8'(i), rnd[i]);
    for (int i = 0; i < 4; i++) poke(8'h70 + 8'(i), rnd[i]);
    run_op(1'b1, rkey, 8'h50, 8'h40, 1'b0);
    run_op(1'b0, rkey, 8'h40, 8'h60, 1'b0);
    for (int i = 0; i < 4; i++) check_eq($sformatf("rt_w%0d", i), mem[8'h60 + 8'(i)], rnd[i]);
    run_op(1'b1, rkey, 8'h70, 8'h70, 1'b0);
    run_op(1'b0, rkey, 8'h70, 8'h70, 1'b0);
    for (int i = 0; i < 4; i++) check_eq($sformatf("inplace_w%0d", i), mem[8'h70 + 8'(i)], rnd[i]);

    // Address wrap with key 1: enc(0)=0x01540, enc(1)=0x00540.
    poke(8'hFE, 19'h0); poke(8'hFF, 19'h1); poke(8'h00, 19'h0); poke(8'h01, 19'h1);
    run_op(1'b1, 19'h1, 8'hFE, 8'hFD, 1'b0);
    check_eq("wrap_rd_a0", rd_a[0], 8'hFE);
    check_eq("wrap_rd_a1", rd_a[1], 8'hFF);
    check_eq("wrap_rd_a2", rd_a[2], 8'h00);
    check_eq("wrap_rd_a3", rd_a[3], 8'h01);
    check_eq("wrap_wr_a0", wr_a[0], 8'hFD);
    check_eq("wrap_wr_a1", wr_a[1], 8'hFE);
    check_eq("wrap_wr_a2", wr_a[2], 8'hFF);
    check_eq("wrap_wr_a3", wr_a[3], 8'h00);
    check_eq("wrap_fe_order", (wr_cyc[1] > rd_cyc[0]), 1);
    check_eq("wrap_m_fd", mem[8'hFD], 19'h01540);
    check_eq("wrap_m_fe", mem[8'hFE], 19'h00540);
    check_eq("wrap_m_ff", mem[8'hFF], 19'h01540);
    check_eq("wrap_m_00", mem[8'h00], 19'h00540);

    // Start held through the run and the DONE cycle: one operation only.
    run_op(1'b1, 19'h0, 8'h10, 8'h24, 1'b1);
    check_eq("hold_wr_n", wr_n, 4);
    check_eq("hold_done_cnt", done_cnt, 1);
    check_eq("hold_busy_last", busy_last, 29);
    check_eq("hold_busy_cnt", busy_cnt, 29);
    check_eq("hold_w0", mem[8'h24], 19'h01000);

    // Reset during the rounds of word 1.
    for (int i = 0; i < 4; i++) poke(8'h80 + 8'(i), 19'h55555);
    @(negedge clk);
    start_in = 1'b1; mode_enc_dec_in = 1'b1; key_in = 19'h0; src_addr_in = 8'h10; dst_addr_in = 8'h80;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      start_in = 1'b0;
    end
    rst = 1'b1;
    @(negedge clk);
    check_idle_outputs("midrst");
    rst = 1'b0;
    wr_after_rst = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (mem_wr_en_out || busy_out) wr_after_rst++;
    end
    check_eq("midrst_quiet", wr_after_rst, 0);
    check_eq("midrst_w0", mem[8'h80], 19'h01000);
    check_eq("midrst_w1", mem[8'h81], 19'h55555);
    run_op(1'b1, 19'h0, 8'h10, 8'h80, 1'b0);
    check_eq("rerun_rd_a0", rd_a[0], 8'h10);
    check_eq("rerun_done_cyc", done_cyc, 29);
    check_eq("rerun_w1", mem[8'h81], 19'h02000);
    check_eq("rerun_w2", mem[8'h82], 19'h00800);
    check_eq("rerun_w3", mem[8'h83], 19'h00000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/cus19_crypto_engine.md
Name: cus19_crypto_engine

Overview:
- S-type responder for the ID-stage control outputs `start_in` and `mode_enc_dec_in`.
- On a start pulse it fetches BLOCK_WORDS 19-bit words from data memory and runs ROUNDS cipher rounds on each word, one round per cycle.
- Each result is written to a destination buffer. Encrypt or decrypt is selected by the latched mode.
- While running it asserts `busy_out`, which stalls the pipeline. `done_out` pulses for one cycle at completion.

Parameters:
- DATA_W, 19, word width
- ADDR_W, 8, data-memory address width
- BLOCK_WORDS, 4, words processed per operation (1..16)
- ROUNDS, 4, cipher rounds per word (1..18)
- ROT, 3, rotate amount per round (1..DATA_W-1)

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- start_in  in  1  start request from control unit; sampled only in IDLE
- mode_enc_dec_in  in  1  1 = encrypt, 0 = decrypt; latched with start
- key_in  in  DATA_W  cipher key; latched with start
- src_addr_in  in  ADDR_W  source base address; latched with start
- dst_addr_in  in  ADDR_W  destination base address; latched with start
- mem_rd_en_out  out  1  memory read request
- mem_wr_en_out  out  1  memory write strobe
- mem_addr_out  out  ADDR_W  memory address
- mem_wdata_out  out  DATA_W  write data
- mem_rdata_in  in  DATA_W  read data, valid one cycle after mem_rd_en_out
- busy_out  out  1  high in every non-IDLE state
- done_out  out  1  one-cycle completion pulse

Behaviour:
- Reset (any cycle, including mid-operation):
  - state = IDLE.
  - All outputs 0.
  - Word index, round counter, data register, latched key, mode and addresses all cleared.
  - Nothing is written after a reset edge.
- FSM states: IDLE, RD_REQ, RD_WAIT, ROUND, WR, DONE.
- IDLE:
  - If start_in=1 at an edge: latch mode, key, src and dst; clear idx; go to RD_REQ.
  - start_in while not in IDLE is ignored; no queueing.
- RD_REQ:
  - mem_rd_en_out=1, mem_addr_out = src + idx.
  - Go to RD_WAIT.
- RD_WAIT:
  - At the edge, capture mem_rdata_in into x and clear the round counter r.
  - Go to ROUND.
- ROUND (ROUNDS cycles), with round key k_i = rotl(key, i mod DATA_W):
  - Encrypt, i = r: x <= rotl(x ^ k_i, ROT).
  - Decrypt, i = ROUNDS-1-r: x <= rotr(x, ROT) ^ k_i.
  - r increments each cycle; after the round with r = ROUNDS-1, go to WR.
- WR:
  - mem_wr_en_out=1, mem_addr_out = dst + idx, mem_wdata_out = x.
  - If idx = BLOCK_WORDS-1, go to DONE; otherwise idx++ and go to RD_REQ.
- DONE:
  - done_out=1 and busy_out=1 for this cycle only.
  - Go to IDLE. A start seen in DONE is ignored.
- Address arithmetic: src+idx and dst+idx are computed modulo 2^ADDR_W (wrap at 0xFF → 0x00).
- Aliasing: src = dst is legal. In-place operation is correct because each word is read before it is written.
- Strobe exclusivity: mem_rd_en_out and mem_wr_en_out are never high in the same cycle. mem_addr_out and mem_wdata_out are 0 when their strobe is low.
- Outputs are registered-state decodes; there is no combinational path from inputs to outputs.
- Latency: start is sampled at cycle 0.
  - Word j write strobe falls in cycle (j+1)(ROUNDS+3).
  - done_out is high in cycle BLOCK_WORDS(ROUNDS+3)+1.
  - Defaults: write strobes in cycles 7, 14, 21, 28; done in cycle 29.
- Correctness: for any key, decrypt(encrypt(x)) = x.

Test Plan:
- Key 0, mode=1, src=0x10 holding {0x00001, 0x00002, 0x40000, 0x00000}, dst=0x20 → writes {0x01000, 0x02000, 0x00800, 0x00000} to 0x20..0x23; done in cycle 29; busy high in cycles 1–29.
- Key 0x7FFFF, mode=1, word 0x00001 → 0x01000; word 0x00000 → 0x00000. Rerunning with mode=0 on the outputs restores the originals.
- Random key and data, encrypt into 0x40, then decrypt from 0x40 to 0x60 → 0x60..0x63 equal the source words; in-place variant (src=dst) gives the same result.
- src=0xFE, dst=0xFD → reads 0xFE, 0xFF, 0x00, 0x01 and writes 0xFD, 0xFE, 0xFF, 0x00. The write to 0xFE occurs after the read of 0xFE.
- start_in held high for the whole run, plus an extra pulse in the DONE cycle → exactly one operation; the next run starts only from a start seen in IDLE.
- rst asserted during the ROUND of word 1 → next cycle all outputs 0, state IDLE, no further mem_wr_en_out; a new start then runs normally from idx 0.
